// File: rtl/idma_chan_arb_pkg.sv
// Shared types and helpers for the iDMA channel arbiter: lock FSM states and a round-robin pick.
// Pure declarations; no state, no latency, no flow control of its own.
package idma_chan_arb_pkg;

    typedef enum logic {
        UNLOCKED = 1'b0,
        LOCKED   = 1'b1
    } lock_state_e;

    localparam int unsigned MaxChannels = 32;
    localparam int unsigned MaxChIdxW   = 5;

    // First valid channel at or after ptr, wrapping modulo num; 0 when nothing is valid.
    function automatic int unsigned rr_pick(
        input logic [MaxChannels-1:0] valid,
        input int unsigned            ptr,
        input int unsigned            num
    );
        int unsigned pick;
        int unsigned idx;
        bit          found;
        pick  = 0;
        idx   = 0;
        found = 1'b0;
        for (int unsigned k = 0; k < MaxChannels; k++) begin
            if (k < num) begin
                idx = (ptr + k) % num;
                if (!found && valid[idx[MaxChIdxW-1:0]]) begin
                    pick  = idx;
                    found = 1'b1;
                end
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/idma_chan_idx_fifo.sv
// Index FIFO recording the granted channel of each accepted request; head visible combinationally.
// Latency: push/pop take effect at the next edge; push ignored when full, pop ignored when empty.
module idma_chan_idx_fifo #(
    parameter int unsigned Depth = 8,
    parameter int unsigned Width = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_vld,
    input  logic [Width-1:0] push_dat,
    input  logic             pop_vld,
    output logic             full,
    output logic             empty,
    output logic [Width-1:0] head_dat
);

    localparam int unsigned PtrWidth = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned OccWidth = $clog2(Depth + 1);
    localparam logic [PtrWidth-1:0] LastPtr = PtrWidth'(Depth - 1);
    localparam logic [OccWidth-1:0] FullOcc = OccWidth'(Depth);

    logic [Width-1:0]    mem [Depth];
    logic [PtrWidth-1:0] wr_ptr;
    logic [PtrWidth-1:0] rd_ptr;
    logic [OccWidth-1:0] occ;
    logic                push_ok;
    logic                pop_ok;

    assign full     = (occ == FullOcc);
    assign empty    = (occ == '0);
    assign push_ok  = push_vld & ~full;
    assign pop_ok   = pop_vld & ~empty;
    assign head_dat = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= (wr_ptr == LastPtr) ? '0 : wr_ptr + PtrWidth'(1);
            end
            if (pop_ok) begin
                rd_ptr <= (rd_ptr == LastPtr) ? '0 : rd_ptr + PtrWidth'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   occ <= occ + OccWidth'(1);
                2'b01:   occ <= occ - OccWidth'(1);
                default: occ <= occ;
            endcase
        end
    end

    // Storage needs no reset: occupancy alone decides what is readable.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_dat;
        end
    end

endmodule

// File: rtl/idma_req_chan_arb.sv
// N-to-1 iDMA request arbiter with in-order response routing; IDMA_REQ_CHAN_ARB_RR_EN selects round-robin over fixed priority.
// Zero-cycle request/response paths; grant locks while the back-end stalls; requests blocked while the index FIFO is full.
module idma_req_chan_arb
    import idma_chan_arb_pkg::*;
#(
    parameter int unsigned NumChannels  = 4,
    parameter int unsigned IdxFifoDepth = 8,
    parameter type         idma_req_t   = logic,
    parameter type         idma_rsp_t   = logic,
    parameter int unsigned ChIdxWidth   = $clog2(NumChannels),
    parameter int unsigned CntWidth     = $clog2(IdxFifoDepth + 1)
) (
    input  logic                               clk_i,
    input  logic                               rst_i,
    input  idma_req_t [NumChannels-1:0]        ch_req_i,
    input  logic      [NumChannels-1:0]        ch_req_valid_i,
    output logic      [NumChannels-1:0]        ch_req_ready_o,
    output idma_rsp_t [NumChannels-1:0]        ch_rsp_o,
    output logic      [NumChannels-1:0]        ch_rsp_valid_o,
    input  logic      [NumChannels-1:0]        ch_rsp_ready_i,
    output logic      [NumChannels-1:0]        ch_busy_o,
    output idma_req_t                          be_req_o,
    output logic                               be_req_valid_o,
    input  logic                               be_req_ready_i,
    input  idma_rsp_t                          be_rsp_i,
    input  logic                               be_rsp_valid_i,
    output logic                               be_rsp_ready_o,
    output logic                               spurious_rsp_o
);

    lock_state_e           lock_state;
    lock_state_e           lock_next;
    logic [ChIdxWidth-1:0] gnt;
    logic [ChIdxWidth-1:0] gnt_arb;
    logic [ChIdxWidth-1:0] gnt_q;
    logic [ChIdxWidth-1:0] head;
    logic [CntWidth-1:0]   cnt [NumChannels];
    logic                  idx_full;
    logic                  idx_empty;
    logic                  any_valid;
    logic                  req_hs;
    logic                  rsp_hs;
    logic                  pop;
    logic                  spurious_q;

    // ---------------- grant selection ----------------
`ifdef IDMA_REQ_CHAN_ARB_RR_EN
    localparam logic [ChIdxWidth-1:0] LastCh = ChIdxWidth'(NumChannels - 1);

    logic [ChIdxWidth-1:0] rr_ptr;

    always_comb begin
        gnt_arb = ChIdxWidth'(rr_pick(MaxChannels'(ch_req_valid_i), 32'(rr_ptr), NumChannels));
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rr_ptr <= '0;
        end else if (req_hs) begin
            rr_ptr <= (gnt == LastCh) ? '0 : gnt + ChIdxWidth'(1);
        end
    end
`else
    always_comb begin
        gnt_arb = '0;
        for (int i = int'(NumChannels) - 1; i >= 0; i--) begin
            if (ch_req_valid_i[i]) begin
                gnt_arb = ChIdxWidth'(i);
            end
        end
    end
`endif

    assign gnt = (lock_state == LOCKED) ? gnt_q : gnt_arb;

    // ---------------- request path ----------------
    assign any_valid      = |ch_req_valid_i;
    assign be_req_valid_o = any_valid & ~idx_full;
    assign be_req_o       = ch_req_i[gnt];
    assign req_hs         = be_req_valid_o & be_req_ready_i;

    always_comb begin
        ch_req_ready_o      = '0;
        ch_req_ready_o[gnt] = be_req_ready_i & ~idx_full;
    end

    // Lock keeps be_req_o stable while the back-end stalls an offered request.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            lock_state <= UNLOCKED;
            gnt_q      <= '0;
        end else begin
            lock_state <= lock_next;
            if (lock_state == UNLOCKED && lock_next == LOCKED) begin
                gnt_q <= gnt_arb;
            end
        end
    end

    always_comb begin
        lock_next = lock_state;
        case (lock_state)
            UNLOCKED: if (be_req_valid_o && !be_req_ready_i) lock_next = LOCKED;
            LOCKED:   if (req_hs) lock_next = UNLOCKED;
            default:  lock_next = UNLOCKED;
        endcase
    end

    idma_chan_idx_fifo #(
        .Depth (IdxFifoDepth),
        .Width (ChIdxWidth)
    ) u_idx_fifo (
        .clk      (clk_i),
        .rst      (rst_i),
        .push_vld (req_hs),
        .push_dat (gnt),
        .pop_vld  (pop),
        .full     (idx_full),
        .empty    (idx_empty),
        .head_dat (head)
    );

    // ---------------- response path ----------------
    assign be_rsp_ready_o = idx_empty | ch_rsp_ready_i[head];
    assign rsp_hs         = be_rsp_valid_i & be_rsp_ready_o;
    assign pop            = rsp_hs & ~idx_empty;
    assign spurious_rsp_o = spurious_q;

    always_comb begin
        ch_rsp_valid_o       = '0;
        ch_rsp_valid_o[head] = be_rsp_valid_i & ~idx_empty;
        for (int i = 0; i < int'(NumChannels); i++) begin
            ch_rsp_o[i] = be_rsp_i;
        end
    end

    // With an empty FIFO the response is accepted and dropped.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            spurious_q <= 1'b0;
        end else begin
            spurious_q <= rsp_hs & idx_empty;
        end
    end

    // ---------------- outstanding counters ----------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < int'(NumChannels); i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < int'(NumChannels); i++) begin
                if ((req_hs && gnt == ChIdxWidth'(i)) && !(pop && head == ChIdxWidth'(i))) begin
                    cnt[i] <= cnt[i] + CntWidth'(1);
                end else if (!(req_hs && gnt == ChIdxWidth'(i)) && (pop && head == ChIdxWidth'(i))) begin
                    cnt[i] <= cnt[i] - CntWidth'(1);
                end
            end
        end
    end

    always_comb begin
        for (int i = 0; i < int'(NumChannels); i++) begin
            ch_busy_o[i] = (cnt[i] != '0);
        end
    end

endmodule

// File: tb/tb_idma_req_chan_arb.sv
module tb_idma_req_chan_arb;

    localparam int NCH   = 4;
    localparam int DEPTH = 4;

    typedef logic [15:0] req_t;
    typedef logic [7:0]  rsp_t;

    logic               clk = 1'b0;
    logic               rst;
    req_t [NCH-1:0]     ch_req;
    logic [NCH-1:0]     ch_req_valid;
    logic [NCH-1:0]     ch_req_ready;
    rsp_t [NCH-1:0]     ch_rsp;
    logic [NCH-1:0]     ch_rsp_valid;
    logic [NCH-1:0]     ch_rsp_ready;
    logic [NCH-1:0]     ch_busy;
    req_t               be_req;
    logic               be_req_valid;
    logic               be_req_ready;
    rsp_t               be_rsp;
    logic               be_rsp_valid;
    logic               be_rsp_ready;
    logic               spurious;

    int checks   = 0;
    int failures = 0;

    // Reference model: outstanding-channel queue in issue order, per-channel counts,
    // round-robin start point, pending stalled grant, spurious flag for next cycle.
    int q[$];
    int cnt_m[NCH];
    int rr_m;
    bit lock_m;
    int lock_ch;
    bit spur_m;

    always #5 clk = ~clk;

    idma_req_chan_arb #(
        .NumChannels  (NCH),
        .IdxFifoDepth (DEPTH),
        .idma_req_t   (req_t),
        .idma_rsp_t   (rsp_t)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .ch_req_i       (ch_req),
        .ch_req_valid_i (ch_req_valid),
        .ch_req_ready_o (ch_req_ready),
        .ch_rsp_o       (ch_rsp),
        .ch_rsp_valid_o (ch_rsp_valid),
        .ch_rsp_ready_i (ch_rsp_ready),
        .ch_busy_o      (ch_busy),
        .be_req_o       (be_req),
        .be_req_valid_o (be_req_valid),
        .be_req_ready_i (be_req_ready),
        .be_rsp_i       (be_rsp),
        .be_rsp_valid_i (be_rsp_valid),
        .be_rsp_ready_o (be_rsp_ready),
        .spurious_rsp_o (spurious)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int exp_gnt();
        if (lock_m) return lock_ch;
`ifdef IDMA_REQ_CHAN_ARB_RR_EN
        for (int k = 0; k < NCH; k++) begin
            int idx = (rr_m + k) % NCH;
            if (ch_req_valid[idx]) return idx;
        end
`else
        for (int k = 0; k < NCH; k++) begin
            if (ch_req_valid[k]) return k;
        end
`endif
        return 0;
    endfunction

    task automatic model_clear();
        q.delete();
        for (int i = 0; i < NCH; i++) cnt_m[i] = 0;
        rr_m    = 0;
        lock_m  = 1'b0;
        lock_ch = 0;
        spur_m  = 1'b0;
    endtask

    // Wait to mid-cycle and compare every output against the model.
    task automatic settle();
        bit             full;
        bit             empty;
        bit             anyv;
        int             g;
        int             head;
        logic [NCH-1:0] busy_e;
        @(negedge clk);
        full  = (q.size() == DEPTH);
        empty = (q.size() == 0);
        anyv  = (ch_req_valid != 0);
        head  = empty ? 0 : q[0];
        chk("be_req_valid", be_req_valid, anyv && !full);
        if (anyv) begin
            g = exp_gnt();
            chk("be_req", be_req, ch_req[g]);
            chk("ch_req_ready", ch_req_ready, (be_req_ready && !full) ? (1 << g) : 0);
        end
        chk("ch_rsp_valid", ch_rsp_valid, (be_rsp_valid && !empty) ? (1 << head) : 0);
        chk("be_rsp_ready", be_rsp_ready, empty || ch_rsp_ready[head]);
        chk("ch_rsp", ch_rsp, {NCH{be_rsp}});
        for (int i = 0; i < NCH; i++) busy_e[i] = (cnt_m[i] != 0);
        chk("ch_busy", ch_busy, busy_e);
        chk("spurious", spurious, spur_m);
    endtask

    // Apply the edge to the model using the current inputs, then move past the edge.
    task automatic advance();
        bit full;
        bit empty;
        bit req_v;
        bit rsp_hs;
        int g;
        int head;
        if (rst) begin
            model_clear();
        end else begin
            full   = (q.size() == DEPTH);
            empty  = (q.size() == 0);
            head   = empty ? 0 : q[0];
            req_v  = (ch_req_valid != 0) && !full;
            g      = exp_gnt();
            rsp_hs = be_rsp_valid && (empty || ch_rsp_ready[head]);
            spur_m = rsp_hs && empty;
            if (rsp_hs && !empty) begin
                void'(q.pop_front());
                cnt_m[head]--;
            end
            if (req_v && be_req_ready) begin
                q.push_back(g);
                cnt_m[g]++;
                rr_m   = (g + 1) % NCH;
                lock_m = 1'b0;
            end else if (req_v) begin
                lock_m  = 1'b1;
                lock_ch = g;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic cyc();
        settle();
        advance();
    endtask

    task automatic idle();
        ch_req       = '0;
        ch_req_valid = '0;
        be_req_ready = 1'b0;
        be_rsp       = '0;
        be_rsp_valid = 1'b0;
        ch_rsp_ready = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle();
        @(posedge clk);
        #1;
        model_clear();
        settle();
        chk("rst_busy", ch_busy, 0);
        chk("rst_be_rsp_ready", be_rsp_ready, 1);
        chk("rst_be_req_valid", be_req_valid, 0);
        chk("rst_spurious", spurious, 0);
        advance();
        rst = 1'b0;
    endtask

    task automatic drain();
        ch_req_valid = '0;
        be_rsp_valid = 1'b1;
        ch_rsp_ready = '1;
        for (int n = 0; n < 32 && q.size() > 0; n++) begin
            be_rsp = rsp_t'($urandom);
            cyc();
        end
        be_rsp_valid = 1'b0;
        settle();
        chk("drain_busy", ch_busy, 0);
        advance();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "simulation did not finish");
    end

    initial begin
        idle();
        do_reset();

        // Two requesters together: ch0 first, then ch2.
        ch_req[0] = 16'hA000;
        ch_req[2] = 16'hA002;
        ch_req_valid = 4'b0101;
        be_req_ready = 1'b1;
        settle(); chk("fp_first", be_req, 16'hA000); advance();
        ch_req_valid = 4'b0100;
        settle(); chk("fp_second", be_req, 16'hA002); advance();
        ch_req_valid = 4'b0000;
        settle(); chk("fp_busy", ch_busy, 4'b0101); advance();
        be_rsp_valid = 1'b1;
        ch_rsp_ready = 4'hF;
        be_rsp = 8'h11;
        settle(); chk("fp_rsp_head0", ch_rsp_valid, 4'b0001); advance();
        be_rsp = 8'h22;
        settle(); chk("fp_rsp_head2", ch_rsp_valid, 4'b0100); advance();
        be_rsp_valid = 1'b0;
        settle(); chk("fp_busy_clear", ch_busy, 0); advance();

        // All channels valid for 8 cycles, responses flowing behind.
        do_reset();
        for (int i = 0; i < NCH; i++) ch_req[i] = req_t'(16'hC000 + i);
        ch_req_valid = 4'hF;
        be_req_ready = 1'b1;
        ch_rsp_ready = 4'hF;
        for (int c = 0; c < 8; c++) begin
            be_rsp_valid = (c > 0);
            settle();
`ifdef IDMA_REQ_CHAN_ARB_RR_EN
            chk("rr_order", be_req, 16'hC000 + (c % NCH));
`else
            chk("fp_order", be_req, 16'hC000);
`endif
            advance();
        end
        drain();

        // Lock: ch1 stalled three cycles while ch0 rises.
        ch_req[0] = 16'hB000;
        ch_req[1] = 16'hB001;
        ch_req_valid = 4'b0010;
        be_req_ready = 1'b0;
        settle(); chk("lock_first", be_req, 16'hB001); advance();
        ch_req_valid = 4'b0011;
        for (int c = 0; c < 2; c++) begin
            settle();
            chk("lock_hold", be_req, 16'hB001);
            chk("lock_noready", ch_req_ready, 0);
            advance();
        end
        be_req_ready = 1'b1;
        settle(); chk("lock_hs", ch_req_ready, 4'b0010); chk("lock_hs_req", be_req, 16'hB001); advance();
        ch_req_valid = 4'b0001;
        settle(); chk("lock_after", be_req, 16'hB000); advance();
        drain();

        // Full FIFO blocks requests, even in the cycle of a pop.
        ch_req_valid = 4'b0100;
        be_req_ready = 1'b1;
        for (int c = 0; c < DEPTH; c++) begin
            ch_req[2] = req_t'(16'hF000 + c);
            settle(); chk("full_fill", be_req_valid, 1); advance();
        end
        settle(); chk("full_blocked", be_req_valid, 0); chk("full_noready", ch_req_ready, 0); advance();
        be_rsp_valid = 1'b1;
        ch_rsp_ready = 4'hF;
        settle(); chk("full_pop_blocks", be_req_valid, 0); chk("full_pop_rdy", be_rsp_ready, 1); advance();
        be_rsp_valid = 1'b0;
        settle(); chk("full_accept", ch_req_ready, 4'b0100); advance();
        drain();

        // Routing: order 3 then 1, ch3 not ready for two cycles.
        be_req_ready = 1'b1;
        ch_req_valid = 4'b1000; cyc();
        ch_req_valid = 4'b0010; cyc();
        ch_req_valid = 4'b0000;
        be_rsp_valid = 1'b1;
        ch_rsp_ready = 4'b0010;
        for (int c = 0; c < 2; c++) begin
            settle();
            chk("route_stall", be_rsp_ready, 0);
            chk("route_stall_vld", ch_rsp_valid, 4'b1000);
            advance();
        end
        ch_rsp_ready = 4'hF;
        settle(); chk("route_ch3", ch_rsp_valid, 4'b1000); advance();
        settle(); chk("route_ch1", ch_rsp_valid, 4'b0010); advance();
        be_rsp_valid = 1'b0;
        settle(); chk("route_cnt_zero", ch_busy, 0); advance();

        // Spurious response with empty FIFO.
        be_rsp_valid = 1'b1;
        settle(); chk("spur_rdy", be_rsp_ready, 1); chk("spur_novld", ch_rsp_valid, 0); advance();
        be_rsp_valid = 1'b0;
        settle(); chk("spur_pulse", spurious, 1); advance();
        settle(); chk("spur_clear", spurious, 0); advance();

        // Reset with three outstanding requests.
        ch_req_valid = 4'b0001; cyc();
        ch_req_valid = 4'b0010; cyc();
        ch_req_valid = 4'b0100; cyc();
        ch_req_valid = 4'b0000;
        settle(); chk("pre_rst_busy", ch_busy, 4'b0111); advance();
        do_reset();
        be_rsp_valid = 1'b1;
        cyc();
        be_rsp_valid = 1'b0;
        settle(); chk("post_rst_spur", spurious, 1); advance();

        // Randomized traffic against the model; stalled channel holds valid and data.
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < NCH; i++) begin
                if (lock_m && i == lock_ch) begin
                    ch_req_valid[i] = 1'b1;
                end else begin
                    ch_req_valid[i] = ($urandom_range(0, 2) == 0);
                    ch_req[i]       = req_t'($urandom);
                end
            end
            be_req_ready = ($urandom_range(0, 3) != 0);
            be_rsp_valid = ($urandom_range(0, 1) == 1);
            be_rsp       = rsp_t'($urandom);
            ch_rsp_ready = NCH'($urandom);
            cyc();
        end
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
